// File: rtl/mgt_01_booth_mul_seq.sv
// Iterative radix-4 Booth multiplier (MUL/MULH/MULHSU/MULHU) with valid/ready, flush and clock enable.
// Optional MGT_01_MUL_ZERO_BYPASS_EN: zero operands skip COMPUTE and complete on the accepting edge.
module mgt_01_booth_mul_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clk_en_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] multiplier_i,
    input  logic [WIDTH-1:0] multiplicand_i,
    input  logic [1:0]       operation_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             busy_o
);

    localparam int unsigned ITER = (WIDTH + 2) / 2;
    localparam int unsigned CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int unsigned AW   = WIDTH + 2;
    localparam int unsigned PW   = WIDTH + 3;
    localparam int unsigned TW   = PW + AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PW-1:0]    r_p;
    logic [AW-1:0]    r_a;
    logic [AW-1:0]    r_b;
    logic             r_l;
    logic [CW-1:0]    r_cnt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_result;

    logic             w_accept;
    logic             w_fin;
    logic             w_skip;
    logic             w_a_sgn;
    logic             w_b_sgn;
    logic [AW-1:0]    w_a_ext;
    logic [AW-1:0]    w_b_ext;
    logic [PW-1:0]    w_bx;
    logic [PW-1:0]    w_b2;
    logic [PW-1:0]    w_addend;
    logic [PW-1:0]    w_psum;
    logic [TW-1:0]    w_shift;
    logic [WIDTH-1:0] w_res;

    assign ready_o  = clk_en_i & ((r_state == S_IDLE) | ((r_state == S_DONE) & ready_i));
    assign w_accept = valid_i & ready_o & ~flush_i;
    assign w_fin    = (r_state == S_COMPUTE) && (r_cnt == CW'(ITER - 1));
    assign valid_o  = (r_state == S_DONE);
    assign busy_o   = (r_state == S_COMPUTE);
    assign result_o = r_result;

`ifdef MGT_01_MUL_ZERO_BYPASS_EN
    assign w_skip = (multiplier_i == '0) | (multiplicand_i == '0);
`else
    assign w_skip = 1'b0;
`endif

    // Extension lets one signed Booth datapath serve all four signedness combinations.
    assign w_a_sgn = (operation_i == 2'b01) | (operation_i == 2'b10);
    assign w_b_sgn = (operation_i == 2'b01);
    assign w_a_ext = {{2{w_a_sgn & multiplier_i[WIDTH-1]}}, multiplier_i};
    assign w_b_ext = {{2{w_b_sgn & multiplicand_i[WIDTH-1]}}, multiplicand_i};

    assign w_bx = {r_b[AW-1], r_b};
    assign w_b2 = {r_b, 1'b0};

    always_comb begin
        w_addend = '0;
        case ({r_a[1:0], r_l})
            3'b001, 3'b010: w_addend = w_bx;
            3'b011:         w_addend = w_b2;
            3'b100:         w_addend = -w_b2;
            3'b101, 3'b110: w_addend = -w_bx;
            default:        w_addend = '0;
        endcase
    end

    assign w_psum  = r_p + w_addend;
    assign w_shift = TW'($signed({w_psum, r_a, r_l}) >>> 2);
    // w_shift[TW-1:1] is the next {P,A}; the product is its low 2*WIDTH bits.
    assign w_res   = (r_op == 2'b00) ? w_shift[WIDTH:1] : w_shift[2*WIDTH:WIDTH+1];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = w_skip ? S_DONE : S_COMPUTE;
            end
            S_COMPUTE: begin
                if (w_fin) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (w_accept)     w_state_nxt = w_skip ? S_DONE : S_COMPUTE;
                else if (ready_i) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else if (flush_i) begin
            r_state <= S_IDLE;
        end else if (clk_en_i) begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_p      <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_l      <= 1'b0;
            r_cnt    <= '0;
            r_op     <= '0;
            r_result <= '0;
        end else if (clk_en_i && !flush_i) begin
            if (w_accept) begin
                r_p   <= '0;
                r_a   <= w_a_ext;
                r_b   <= w_b_ext;
                r_l   <= 1'b0;
                r_cnt <= '0;
                r_op  <= operation_i;
                if (w_skip) r_result <= '0;
            end else if (r_state == S_COMPUTE) begin
                r_p   <= w_shift[TW-1:AW+1];
                r_a   <= w_shift[AW:1];
                r_l   <= w_shift[0];
                r_cnt <= r_cnt + 1'b1;
                if (w_fin) r_result <= w_res;
            end
        end
    end

endmodule

// File: tb/tb_mgt_01_booth_mul_seq.sv
// Directed self-checking bench for mgt_01_booth_mul_seq (WIDTH=32, 17-edge latency).
module tb_mgt_01_booth_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        clk_en_i;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] multiplier_i;
    logic [31:0] multiplicand_i;
    logic [1:0]  operation_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;

    mgt_01_booth_mul_seq #(.WIDTH(32)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n_i),
        .clk_en_i       (clk_en_i),
        .flush_i        (flush_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .multiplier_i   (multiplier_i),
        .multiplicand_i (multiplicand_i),
        .operation_i    (operation_i),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .result_o       (result_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        operation_i    = op;
        multiplier_i   = a;
        multiplicand_i = b;
        valid_i        = 1'b1;
        @(negedge clk);
        valid_i        = 1'b0;
    endtask

    task automatic wait_res(output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        while (!valid_o && cyc < 100) begin
            if (busy_o) bcnt++;
            @(negedge clk);
            cyc++;
        end
        if (!valid_o) check("timeout", 32'd0, 32'd1);
    endtask

    task automatic consume(input string tag);
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        check({tag, "_vld_clr"}, 32'(valid_o), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int c, bc;
        issue(op, a, b);
        wait_res(c, bc);
        check({tag, "_lat"}, 32'(c), 32'd17);
        check({tag, "_res"}, result_o, exp);
        consume(tag);
    endtask

    initial begin
        int c, bc, vcnt;
        logic [31:0] held;
        rst_n_i = 1'b0; clk_en_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        multiplier_i = '0; multiplicand_i = '0; operation_i = '0;
        #12;
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_result", result_o, 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_ready", 32'(ready_o), 32'd1);
        rst_n_i = 1'b1;
        @(negedge clk);

        clk_en_i = 1'b0;
        #1 check("idle_ready_no_en", 32'(ready_o), 32'd0);
        clk_en_i = 1'b1;
        @(negedge clk);

        issue(2'b00, 32'd7, 32'hFFFF_FFFD);
        wait_res(c, bc);
        check("t1_lat", 32'(c), 32'd17);
        check("t1_busy_cycles", 32'(bc), 32'd17);
        check("t1_res", result_o, 32'hFFFF_FFEB);
        consume("t1");

        run_op("t2_mulhu", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("t2_mulh", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        run_op("t2_mulhsu", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("t2_mul", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op("t3_mulh", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op("t3_mulhu", 2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op("t3_mulhsu", 2'b10, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000);

        issue(2'b00, 32'd9, 32'd9);
        wait_res(c, bc);
        check("t4_res0", result_o, 32'h0000_0051);
        held = result_o;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold_res", result_o, held);
            check("t4_hold_ready", 32'(ready_o), 32'd0);
        end
        ready_i = 1'b1; valid_i = 1'b1;
        operation_i = 2'b00; multiplier_i = 32'd3; multiplicand_i = 32'd5;
        #1 check("t4_ready_comb", 32'(ready_o), 32'd1);
        @(negedge clk);
        valid_i = 1'b0; ready_i = 1'b0;
        check("t4_b2b_busy", 32'(busy_o), 32'd1);
        wait_res(c, bc);
        check("t4_lat", 32'(c), 32'd17);
        check("t4_res", result_o, 32'h0000_000F);
        consume("t4");

        issue(2'b00, 32'd1234, 32'd5678);
        repeat (8) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("t5_flush_ready", 32'(ready_o), 32'd1);
        check("t5_flush_busy", 32'(busy_o), 32'd0);
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (valid_o) vcnt++;
            @(negedge clk);
        end
        check("t5_flush_no_valid", 32'(vcnt), 32'd0);
        run_op("t5_after_flush", 2'b00, 32'd2, 32'd2, 32'h0000_0004);

        issue(2'b00, 32'd1234, 32'd5678);
        repeat (8) @(negedge clk);
        #1 rst_n_i = 1'b0;
        #1 check("t5_rst_busy", 32'(busy_o), 32'd0);
        #1 rst_n_i = 1'b1;
        @(negedge clk);
        check("t5_rst_ready", 32'(ready_o), 32'd1);
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (valid_o) vcnt++;
            @(negedge clk);
        end
        check("t5_rst_no_valid", 32'(vcnt), 32'd0);
        run_op("t5_after_rst", 2'b00, 32'd2, 32'd2, 32'h0000_0004);

        issue(2'b00, 32'd123, 32'd456);
        repeat (5) @(negedge clk);
        clk_en_i = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_frozen_busy", 32'(busy_o), 32'd1);
        check("t6_frozen_valid", 32'(valid_o), 32'd0);
        clk_en_i = 1'b1;
        wait_res(c, bc);
        check("t6_lat", 32'(c + 8), 32'd20);
        check("t6_res", result_o, 32'h0000_DB18);
        consume("t6");

        issue(2'b00, 32'd0, 32'h1234);
        wait_res(c, bc);
`ifdef MGT_01_MUL_ZERO_BYPASS_EN
        check("t6_bypass_fast", 32'(c <= 1), 32'd1);
`else
        check("t6_zero_lat", 32'(c), 32'd17);
`endif
        check("t6_zero_res", result_o, 32'd0);
        consume("t6_zero");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
